pe_nic: RTL
===========

Name: pe_nic

Overview:
- Network interface between a processing element (PE) and the router's PE port.
- The PE writes outbound packets into an injection FIFO and reads arrived packets from an ejection FIFO, both through a 2-bit register-mapped interface.
- Injection follows the router's even/odd polarity scheme: the head packet is offered only in cycles where its VC bit (63) equals the router polarity.
- Ejection accepts packets from the router's PE output channel with a ready/send handshake.

Parameters:
- DEPTH, 4, entries per FIFO (power of 2, minimum 2).
- PTR_W, 2, log2(DEPTH); the count width is PTR_W+1.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- polarity  input  1  router polarity (from the router's polarity_out).
- nic_en  input  1  PE access enable.
- nic_we  input  1  1 = write, 0 = read (qualified by nic_en).
- addr  input  2  0 = eject data, 1 = eject status, 2 = inject data, 3 = inject status.
- d_in  input  64  PE write data.
- d_out  output  64  PE read data, combinational.
- net_so  output  1  send to router PE input channel.
- net_ro  input  1  router PE input channel ready.
- net_do  output  64  packet to router (pedi).
- net_si  input  1  router PE output channel send (peso).
- net_ri  output  1  NIC ready to accept (pero).
- net_di  input  64  packet from router (pedo).

Behaviour:
- Reset (reset=0, async): both FIFOs empty, pointers and counts 0.
  - Outputs during reset: net_so=0, net_ri=1 (FIFO not full), net_do=0, d_out=0.
- Packet fields (shared package):
  - 63 VC; 62 NS direction; 61 EW direction; 60:56 reserved.
  - 55:52 Y hops; 51:48 X hops; 47:40 Y source; 39:32 X source; 31:0 payload.
  - The NIC does not modify packets.
- Ejection path:
  - net_ri = ~ej_full.
  - On a posedge with net_si & net_ri, push net_di.
  - net_si while full is ignored; the router must hold.
- PE eject read (nic_en & ~nic_we & addr==0):
  - d_out = ej head; pop at the posedge.
  - Read while empty returns 0, no pop.
- Eject status (addr==1): d_out = {48'b0, 5'b0, ej_count[PTR_W:0] in bits 10:8, 7'b0, ~ej_empty in bit 0}.
- PE inject write (nic_en & nic_we & addr==2):
  - Push d_in at the posedge if not full.
  - If full, the write is dropped and a sticky drop flag (bit 1 of inject status) is set.
  - The drop flag clears on reset or on a read of addr 3.
- Inject status (addr==3): d_out = {count in bits 10:8, drop flag in bit 1, inj_full in bit 0}, other bits 0.
- Injection:
  - net_so = ~inj_empty & net_ro & (inj_head[63] == polarity), combinational.
  - net_do = inj head when ~inj_empty, else 0.
  - Pop at the posedge where net_so=1.
  - Head-of-line blocking is intended: a head packet with the wrong VC waits one cycle for the polarity flip.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle: both occur, count unchanged.
  - When full, a same-cycle PE write is still dropped, even if a pop occurs in that cycle. Full is evaluated on pre-edge state.
  - When empty, a same-cycle read returns 0 and the pushed entry is visible next cycle (no bypass).
- Pointer arithmetic: pointers wrap modulo DEPTH; count is PTR_W+1 bits; full = (count==DEPTH).
- Latency:
  - A PE write is eligible for net_so in the next cycle.
  - A router push is readable via addr 0 in the next cycle.
- nic_en=0: d_out=0, no FIFO side effects.
- Reset mid-operation discards all buffered packets immediately; net_so drops asynchronously.

Decomposition:
- Shared package `noc_pkg`:
  - Field localparams: VC_BIT=63, NS_BIT=62, EW_BIT=61, Y_HOP_MSB=55, X_HOP_MSB=51, Y_SRC_MSB=47, X_SRC_MSB=39, HOP_W=4, SRC_W=8.
  - NIC address constants: ADDR_EJ_DATA=0, ADDR_EJ_STAT=1, ADDR_INJ_DATA=2, ADDR_INJ_STAT=3.
- One sub-module `nic_fifo` (parameter DEPTH; push, pop, din, dout=head, full, empty, count), instantiated twice.
- The pe_nic top holds the handshake, decode and drop-flag logic.

Test Plan:
- Reset: release reset with polarity toggling → net_so=0, net_ri=1, addr1 read = 0, addr3 read = 0.
- Inject with polarity match: write 64'h8000_0000_0000_00AA, net_ro=1 → net_so asserts only in a cycle with polarity=1; net_do matches the written word; after the pop, addr3 bit0=0 and count=0.
- Inject blocked by net_ro: hold net_ro=0, write DEPTH=4 packets, then a 5th of 64'h1 → addr3 = 0x403 (count 4, drop=1, full=1); a re-read of addr3 shows bit1=0; releasing net_ro drains 4 packets in order, one per matching polarity cycle.
- Eject fill: router sends 4 packets 64'h...01 to 64'h...04 on consecutive cycles → net_ri=0 after the 4th; a held 5th net_si is not accepted until one addr0 read, then it is accepted next edge; reads return 1,2,3,4,5 in order.
- Simultaneous push/pop: ejection FIFO at count 2, net_si=1 and addr0 read in the same cycle → count stays 2, read returns the old head.
- Async reset mid-drain: assert reset=0 between clock edges with 3 queued injection packets → net_so falls immediately; after release, inject status=0 and no stale packet is emitted.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field positions and the NIC register map.
package noc_pkg;

    localparam int PKT_W     = 64;
    localparam int VC_BIT    = 63;
    localparam int NS_BIT    = 62;
    localparam int EW_BIT    = 61;
    localparam int Y_HOP_MSB = 55;
    localparam int X_HOP_MSB = 51;
    localparam int Y_SRC_MSB = 47;
    localparam int X_SRC_MSB = 39;
    localparam int HOP_W     = 4;
    localparam int SRC_W     = 8;

    localparam logic [1:0] ADDR_EJ_DATA  = 2'd0;
    localparam logic [1:0] ADDR_EJ_STAT  = 2'd1;
    localparam logic [1:0] ADDR_INJ_DATA = 2'd2;
    localparam logic [1:0] ADDR_INJ_STAT = 2'd3;

    typedef logic [PKT_W-1:0] pkt_t;

endpackage

// File: rtl/pe_nic_if.sv
// PE register bus plus both router PE-port channels of the NIC.
// Router channels: a word moves on a posedge where the sender's send and the
// receiver's ready are both high; the sender holds data stable until then.
interface pe_nic_if;
    import noc_pkg::*;

    logic       polarity;
    logic       nic_en;
    logic       nic_we;
    logic [1:0] addr;
    pkt_t       d_in;
    pkt_t       d_out;
    logic       net_so;
    logic       net_ro;
    pkt_t       net_do;
    logic       net_si;
    logic       net_ri;
    pkt_t       net_di;

    modport master (
        output polarity, nic_en, nic_we, addr, d_in, net_ro, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );

    modport slave (
        input  polarity, nic_en, nic_we, addr, d_in, net_ro, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

endinterface

// File: rtl/nic_fifo.sv
// Circular-buffer FIFO with head-of-queue output; push is ignored when full
// and pop when empty, so callers may request unconditionally.
module nic_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int W     = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   din_i,
    output logic [W-1:0]   dout_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ONE_PTR;
        if (do_pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: every reader gates the head with empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pe_nic.sv
// PE network interface: injection FIFO toward the router (polarity gated)
// and ejection FIFO from the router, both reached through a 2-bit register map.
module pe_nic
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     reset,
    pe_nic_if.slave  bus
);

    pkt_t           inj_head, ej_head;
    logic           inj_full, inj_empty, ej_full, ej_empty;
    logic [PTR_W:0] inj_count, ej_count;
    logic           pe_rd, ej_rd, inj_wr, stat_rd;
    logic           drop_q, drop_d;
    pkt_t           rd_data;

    assign pe_rd   = bus.nic_en & ~bus.nic_we;
    assign ej_rd   = pe_rd & (bus.addr == ADDR_EJ_DATA);
    assign stat_rd = pe_rd & (bus.addr == ADDR_INJ_STAT);
    assign inj_wr  = bus.nic_en & bus.nic_we & (bus.addr == ADDR_INJ_DATA);

    // Head-of-line blocking is deliberate: a wrong-VC head waits for the flip.
    assign bus.net_so = ~inj_empty & bus.net_ro & (inj_head[VC_BIT] == bus.polarity);
    assign bus.net_do = inj_empty ? '0 : inj_head;
    assign bus.net_ri = ~ej_full;

    nic_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(PKT_W)) u_inj_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (inj_wr),
        .pop_i   (bus.net_so),
        .din_i   (bus.d_in),
        .dout_o  (inj_head),
        .full_o  (inj_full),
        .empty_o (inj_empty),
        .count_o (inj_count)
    );

    nic_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(PKT_W)) u_ej_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (bus.net_si),
        .pop_i   (ej_rd),
        .din_i   (bus.net_di),
        .dout_o  (ej_head),
        .full_o  (ej_full),
        .empty_o (ej_empty),
        .count_o (ej_count)
    );

    // Full is sampled pre-edge, so a write into a full FIFO drops even if
    // the router drains an entry on the same edge.
    always_comb begin
        drop_d = drop_q;
        if (stat_rd)                drop_d = 1'b0;
        else if (inj_wr & inj_full) drop_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_q <= 1'b0;
        else        drop_q <= drop_d;
    end

    always_comb begin
        rd_data = '0;
        if (pe_rd) begin
            case (bus.addr)
                ADDR_EJ_DATA:  rd_data = ej_empty ? '0 : ej_head;
                ADDR_EJ_STAT: begin
                    rd_data[8 +: PTR_W+1] = ej_count;
                    rd_data[0]            = ~ej_empty;
                end
                ADDR_INJ_STAT: begin
                    rd_data[8 +: PTR_W+1] = inj_count;
                    rd_data[1]            = drop_q;
                    rd_data[0]            = inj_full;
                end
                default:       rd_data = '0;
            endcase
        end
    end

    assign bus.d_out = rd_data;

endmodule
